// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures decoded operands and control fields from ID and presents them to EX
// one cycle later. The load-use hazard check is built in. Bubbles are inserted
// on a branch flush or a load-use hazard. The register freezes while the
// downstream stage stalls.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   id_*             decoded instruction fields from ID (valid, pc, operands,
//                    imm, register indices, func3/func7, ALU and memory controls)
//   stall_in         EX/MEM cannot accept; hold every ex_* field
//   flush            branch taken in EX; replace the ID instruction with a bubble
//   ex_*             registered copies of the id_* fields
//   load_use_stall   combinational; freeze PC and IF/ID this cycle
//   bubble_cnt       saturating count of bubbles inserted since reset
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_func3,
  input  logic             id_func7,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             stall_in,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_func3,
  output logic             ex_func7,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Valid + 4 data words + 3 reg indices (15) + func3/func7 (4) + alu_op (2) + 6 control bits
  localparam int BW = 4 * XLEN + 28;

  logic [BW-1:0]    w_id_bundle;
  logic [BW-1:0]    r_ex_bundle;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_load_use;
  logic             w_bubble;

  // A bubble is the all-zero bundle, so one packed vector carries every field.
  assign w_id_bundle = {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
                        id_rs1, id_rs2, id_rd, id_func3, id_func7, id_alu_op,
                        id_alu_src, id_mem_read, id_mem_write, id_reg_write,
                        id_mem_to_reg, id_branch};

  assign {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_func3, ex_func7, ex_alu_op,
          ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
          ex_mem_to_reg, ex_branch} = r_ex_bundle;

  // rs2 counts only when it is actually read: as the ALU B operand or as store data.
  always_comb begin
    w_load_use = rst_n & id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) |
                  ((ex_rd == id_rs2) & (~id_alu_src | id_mem_write)));
    w_bubble   = ~stall_in & (flush | w_load_use);
  end

  assign load_use_stall = w_load_use;
  assign bubble_cnt     = r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_bundle <= '0;
    end else if (!stall_in) begin
      if (w_bubble) r_ex_bundle <= '0;
      else          r_ex_bundle <= w_id_bundle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (CNT_W=2 so saturation is reachable).
// A behavioural model keeps the expected EX-stage contents and bubble count.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  func3;
    logic        func7;
    logic [1:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    stall_in = 1'b0;
  logic    flush = 1'b0;
  bundle_t id = '0;

  logic        ex_valid, ex_func7, ex_alu_src, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg, ex_branch, load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_func3;
  logic [1:0]  ex_alu_op, bubble_cnt;
  bundle_t     dut_ex;

  assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_func3, ex_func7, ex_alu_op,
                   ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                   ex_mem_to_reg, ex_branch};

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_pc(id.pc), .id_rs1_data(id.rs1_data),
    .id_rs2_data(id.rs2_data), .id_imm(id.imm), .id_rs1(id.rs1),
    .id_rs2(id.rs2), .id_rd(id.rd), .id_func3(id.func3), .id_func7(id.func7),
    .id_alu_op(id.alu_op), .id_alu_src(id.alu_src), .id_mem_read(id.mem_read),
    .id_mem_write(id.mem_write), .id_reg_write(id.reg_write),
    .id_mem_to_reg(id.mem_to_reg), .id_branch(id.branch),
    .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func3(ex_func3), .ex_func7(ex_func7),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  // Reference model state
  bundle_t     m_ex = '0;
  int unsigned m_cnt = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic m_hazard();
    return rst_n && id.valid && m_ex.valid && m_ex.mem_read && (m_ex.rd != 0) &&
           ((m_ex.rd == id.rs1) ||
            ((m_ex.rd == id.rs2) && (!id.alu_src || id.mem_write)));
  endfunction

  function automatic bundle_t rand_id();
    bundle_t b;
    b.valid      = ($urandom_range(0, 3) != 0);
    b.pc         = $urandom;
    b.rs1_data   = $urandom;
    b.rs2_data   = $urandom;
    b.imm        = $urandom;
    b.rs1        = 5'($urandom_range(0, 3));
    b.rs2        = 5'($urandom_range(0, 3));
    b.rd         = 5'($urandom_range(0, 3));
    b.func3      = 3'($urandom);
    b.func7      = 1'($urandom);
    b.alu_op     = 2'($urandom);
    b.alu_src    = 1'($urandom);
    b.mem_read   = 1'($urandom);
    b.mem_write  = 1'($urandom);
    b.reg_write  = 1'($urandom);
    b.mem_to_reg = 1'($urandom);
    b.branch     = 1'($urandom);
    return b;
  endfunction

  // Apply ID inputs shortly after a falling edge.
  task automatic drive(input bundle_t b, input logic st, input logic fl);
    id = b;
    stall_in = st;
    flush = fl;
    #1;
  endtask

  // Advance one rising edge, update the model, return to the falling edge.
  task automatic tick();
    logic hz;
    @(posedge clk);
    hz = m_hazard();
    if (rst_n && !stall_in) begin
      if (flush || hz) begin
        m_ex = '0;
        if (m_cnt < 3) m_cnt++;
      end else begin
        m_ex = id;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_ex = '0;
    m_cnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bundle_t b;
    drive('0, 1'b0, 1'b0);
    n_vec++;
    if (dut_ex !== '0 || bubble_cnt !== 2'd0) begin
      $display("FAIL reset_initial got ex=%h cnt=%0d want 0", dut_ex, bubble_cnt); n_miss++;
    end
    #5 rst_n = 1'b1;
    @(negedge clk);
    b = rand_id(); b.valid = 1'b1; b.mem_read = 1'b0;
    drive(b, 1'b0, 1'b0);
    tick();
    drive('0, 1'b0, 1'b1);
    tick();
    drive(b, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (dut_ex !== b || bubble_cnt !== 2'd1) begin
      $display("FAIL reset_preload got ex=%h cnt=%0d want ex=%h cnt=1", dut_ex, bubble_cnt, b); n_miss++;
    end
    // Asynchronous assert mid-cycle, away from any rising edge
    #2 rst_n = 1'b0;
    m_ex = '0; m_cnt = 0;
    #1;
    n_vec++;
    if (dut_ex !== '0 || bubble_cnt !== 2'd0 || load_use_stall !== 1'b0) begin
      $display("FAIL reset_async got ex=%h cnt=%0d lus=%b want 0", dut_ex, bubble_cnt, load_use_stall); n_miss++;
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    b = rand_id(); b.valid = 1'b1;
    drive(b, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (dut_ex !== b || bubble_cnt !== 2'd0) begin
      $display("FAIL reset_release got ex=%h cnt=%0d want ex=%h cnt=0", dut_ex, bubble_cnt, b); n_miss++;
    end
  endtask

  task automatic test_pass_through();
    bundle_t b;
    b = '0;
    b.valid = 1'b1; b.alu_op = 2'b11; b.func3 = 3'b101; b.func7 = 1'b1;
    b.rd = 5'd7; b.rs1_data = 32'h1234; b.rs1 = 5'd3; b.rs2 = 5'd4;
    b.reg_write = 1'b1; b.pc = 32'h0000_0040;
    drive(b, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (dut_ex !== b || ex_valid !== 1'b1 || ex_alu_op !== 2'b11) begin
      $display("FAIL pass_through got %h want %h", dut_ex, b); n_miss++;
    end
  endtask

  task automatic test_load_use();
    bundle_t lw, add;
    do_reset();
    lw = '0; lw.valid = 1'b1; lw.mem_read = 1'b1; lw.rd = 5'd5;
    lw.reg_write = 1'b1; lw.mem_to_reg = 1'b1; lw.alu_src = 1'b1; lw.func3 = 3'b010;
    drive(lw, 1'b0, 1'b0);
    tick();
    add = '0; add.valid = 1'b1; add.rd = 5'd6; add.rs1 = 5'd5; add.rs2 = 5'd1;
    add.alu_op = 2'b11; add.reg_write = 1'b1; add.rs1_data = 32'hdead_beef;
    drive(add, 1'b0, 1'b0);
    n_vec++;
    if (load_use_stall !== 1'b1) begin
      $display("FAIL load_use_detect got %b want 1", load_use_stall); n_miss++;
    end
    tick();
    n_vec++;
    if (dut_ex !== '0 || bubble_cnt !== 2'd1 || load_use_stall !== 1'b0) begin
      $display("FAIL load_use_bubble got ex=%h cnt=%0d lus=%b want 0/1/0", dut_ex, bubble_cnt, load_use_stall); n_miss++;
    end
    tick();
    n_vec++;
    if (dut_ex !== add || bubble_cnt !== 2'd1) begin
      $display("FAIL load_use_reload got %h cnt=%0d want %h cnt=1", dut_ex, bubble_cnt, add); n_miss++;
    end
  endtask

  task automatic test_no_false_hazard();
    bundle_t lw, nxt;
    lw = '0; lw.valid = 1'b1; lw.mem_read = 1'b1; lw.rd = 5'd0;
    drive(lw, 1'b0, 1'b0);
    tick();
    nxt = '0; nxt.valid = 1'b1; nxt.rs1 = 5'd0; nxt.rs2 = 5'd0;
    drive(nxt, 1'b0, 1'b0);
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      $display("FAIL hazard_x0 got %b want 0", load_use_stall); n_miss++;
    end
    lw.rd = 5'd5;
    drive(lw, 1'b0, 1'b0);
    tick();
    nxt = '0; nxt.valid = 1'b1; nxt.rs1 = 5'd2; nxt.rs2 = 5'd5; nxt.alu_src = 1'b1; nxt.rd = 5'd6;
    drive(nxt, 1'b0, 1'b0);
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      $display("FAIL hazard_imm_rs2 got %b want 0", load_use_stall); n_miss++;
    end
    nxt.mem_write = 1'b1; nxt.rd = 5'd0;
    drive(nxt, 1'b0, 1'b0);
    n_vec++;
    if (load_use_stall !== 1'b1) begin
      $display("FAIL hazard_store_rs2 got %b want 1", load_use_stall); n_miss++;
    end
    nxt.valid = 1'b0;
    drive(nxt, 1'b0, 1'b0);
    n_vec++;
    if (load_use_stall !== 1'b0) begin
      $display("FAIL hazard_id_invalid got %b want 0", load_use_stall); n_miss++;
    end
    tick();
  endtask

  task automatic test_priority();
    bundle_t a, b;
    logic [1:0] cnt0;
    do_reset();
    a = rand_id(); a.valid = 1'b1; a.alu_op = 2'b10;
    drive(a, 1'b0, 1'b0);
    tick();
    cnt0 = bubble_cnt;
    b = rand_id();
    drive(b, 1'b1, 1'b1);
    tick();
    n_vec++;
    if (dut_ex !== a || bubble_cnt !== cnt0) begin
      $display("FAIL prio_stall got %h cnt=%0d want %h cnt=%0d", dut_ex, bubble_cnt, a, cnt0); n_miss++;
    end
    drive(b, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (dut_ex !== '0 || ex_alu_op !== 2'b00 || bubble_cnt !== 2'd1) begin
      $display("FAIL prio_flush got %h cnt=%0d want 0 cnt=1", dut_ex, bubble_cnt); n_miss++;
    end
  endtask

  task automatic test_saturation();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    bundle_t b;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b = rand_id();
      drive(b, 1'b0, 1'b1);
      tick();
      n_vec++;
      if (bubble_cnt !== 2'(exp_cnt[i])) begin
        $display("FAIL saturate[%0d] got %0d want %0d", i, bubble_cnt, exp_cnt[i]); n_miss++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(rand_id(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      n_vec++;
      if (load_use_stall !== m_hazard()) begin
        $display("FAIL rand_lus[%0d] got %b want %b", i, load_use_stall, m_hazard()); n_miss++;
      end
      tick();
      n_vec++;
      if (dut_ex !== m_ex || bubble_cnt !== 2'(m_cnt)) begin
        $display("FAIL rand_ex[%0d] got %h cnt=%0d want %h cnt=%0d", i, dut_ex, bubble_cnt, m_ex, m_cnt); n_miss++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_priority();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
